// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side slave for the multicycle core's fetch/load/store
//            request interface. Accepts one request at a time, inserts
//            WAIT_CYCLES wait states, then returns a one-cycle response
//            carrying extended load data or an access-fault flag.
// Ports    : clk_i, rstn_i          - clock (rising edge), sync active-low reset
//            req_valid_i/ready_o    - request handshake
//            req_we_i, req_addr_i,
//            req_wdata_i, req_size_i,
//            req_unsigned_i         - request attributes
//            rsp_valid_o, rsp_rdata_o,
//            rsp_err_o              - one-cycle response strobe and payload
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Decode / datapath wires, all derived from the latched request
  logic [31:0]      offset;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             misalign;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic [3:0]       be;
  logic [31:0]      bit_mask;
  logic [31:0]      wdata_lane;
  logic [31:0]      merged;
  logic             mem_we;
  logic             accept;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  // Array is deliberately not reset. The write happens on the edge that ends
  // RESP; an asserted reset on that edge discards the pending store.
  always_ff @(posedge clk_i) begin
    if (rstn_i && mem_we) begin
      mem_q[idx] <= merged;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  assign accept = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address decode and access checks
  // --------------------------------------------------------------------------
  // Subtraction wraps for addresses below BASE_ADDR, which lands the index far
  // above DEPTH_WORDS and so is caught by the same range check.
  assign offset   = addr_q - BASE_ADDR;
  assign lane     = offset[1:0];
  assign idx      = offset[IDX_W+1:2];
  assign in_range = ({2'b00, offset[31:2]} < DEPTH_WORDS);

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = lane[0];
      SZ_WORD: misalign = (lane != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  assign acc_err = misalign | ~in_range;

  // --------------------------------------------------------------------------
  // Load path
  // --------------------------------------------------------------------------
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_shift;
    case (size_q)
      SZ_BYTE: load_data = uns_q ? {24'h0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_data = uns_q ? {16'h0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // --------------------------------------------------------------------------
  // Store path: replicate data across lanes, then merge under byte enables
  // --------------------------------------------------------------------------
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << lane;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = wdata_q;
      end
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_mask
    assign bit_mask[8*b +: 8] = {8{be[b]}};
  end

  assign merged = (rd_word & ~bit_mask) | (wdata_lane & bit_mask);
  assign mem_we = (state_q == ST_RESP) & we_q & ~acc_err;

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = 32'd0;
    case (state_q)
      ST_IDLE: req_ready_o = rstn_i;
      ST_RESP: begin
        rsp_valid_o = rstn_i;
        rsp_err_o   = rstn_i & acc_err;
        if (rstn_i && !we_q && !acc_err) begin
          rsp_rdata_o = load_data;
        end
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. Three instances cover
//            WAIT_CYCLES = 0, 1 and 3; the WAIT_CYCLES = 1 instance is
//            checked against a byte-addressed reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int unsigned M_DEPTH = 64;
  localparam logic [31:0] M_BASE  = 32'h8000_0000;
  localparam int unsigned S_DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1 (main), index 2: WAIT_CYCLES=3
  logic        rstn         [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory for the main instance, one entry per byte (little endian)
  logic [7:0] mb [M_DEPTH*4];

  mem_responder #(.DEPTH_WORDS(S_DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_size_i(req_size[0]), .req_unsigned_i(req_unsigned[0]), .rsp_valid_o(rsp_valid[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

  mem_responder #(.DEPTH_WORDS(M_DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(M_BASE)) u_dut_w1 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_size_i(req_size[1]), .req_unsigned_i(req_unsigned[1]), .rsp_valid_o(rsp_valid[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

  mem_responder #(.DEPTH_WORDS(S_DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut_w3 (
    .clk_i(clk), .rstn_i(rstn[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_we_i(req_we[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .req_size_i(req_size[2]), .req_unsigned_i(req_unsigned[2]), .rsp_valid_o(rsp_valid[2]),
    .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] off, input logic [31:0] wd,
                              input logic [1:0] sz, input logic un, input logic [31:0] exp_rd,
                              input logic exp_err, input string name);
    vec_t v;
    v.we = we; v.off = off; v.wd = wd; v.sz = sz; v.un = un;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  // Behavioural model: byte-addressed memory with alignment and range rules.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic un,
                              output logic [31:0] rd, output logic er);
    longint off;
    int nb;
    logic [31:0] v;
    off = longint'(a) - longint'(M_BASE);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er  = (sz == 2'd3) || (off < 0) || (off >= longint'(4*M_DEPTH)) || ((off % nb) != 0);
    rd  = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mb[int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[int'(off) + i];
        if (nb < 4 && !un && v[8*nb-1]) begin
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endtask

  // One complete transaction on instance d; lat counts cycles from the
  // accepting edge to the cycle in which rsp_valid is seen (-1 on timeout).
  task automatic do_req(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic un,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    bit got;
    rd = 32'hDEAD_DEAD;
    er = 1'bx;
    lat = -1;
    got = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_wdata[d] = wd; req_size[d] = sz; req_unsigned[d] = un;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      check("ready_timeout", {31'd0, req_ready[d]}, 32'd1);
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        rd = rsp_rdata[d];
        er = rsp_err[d];
        lat = i;
        got = 1;
        break;
      end
    end
    if (got) begin
      @(negedge clk);
      check("rsp_one_cycle", {31'd0, rsp_valid[d]}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, mrd, v, off;
    logic er, mer, we, un;
    logic [1:0] sz;
    int lat, r;

    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
    end

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("rst_rdata", rsp_rdata[1], 32'd0);
    check("rst_err",   {31'd0, rsp_err[1]}, 32'd0);
    check("rst_ready", {31'd0, req_ready[1]}, 32'd0);
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("ready_after_rst%0d", d), {31'd0, req_ready[d]}, 32'd1);

    // ---------------- fill main array with known data ----------------
    for (int w = 0; w < int'(M_DEPTH); w++) begin
      v = $urandom();
      do_req(1, 1'b1, M_BASE + 32'(4*w), v, 2'd2, 1'b0, rd, er, lat);
      model_access(1'b1, M_BASE + 32'(4*w), v, 2'd2, 1'b0, mrd, mer);
      check("init_err", {31'd0, er}, 32'd0);
    end

    // ---------------- directed vector table (WAIT_CYCLES=1) ----------------
    tbl.push_back(mk(1, 32'h10,  32'hDEADBEEF, 2, 0, 32'h0,        0, "sw_10"));
    tbl.push_back(mk(0, 32'h10,  32'h0,        2, 0, 32'hDEADBEEF, 0, "lw_10"));
    tbl.push_back(mk(0, 32'h10,  32'h0,        2, 1, 32'hDEADBEEF, 0, "lw_10_uns"));
    tbl.push_back(mk(1, 32'h20,  32'h11223344, 2, 0, 32'h0,        0, "sw_20"));
    tbl.push_back(mk(1, 32'h21,  32'hABCDEF80, 0, 0, 32'h0,        0, "sb_21"));
    tbl.push_back(mk(1, 32'h22,  32'h9999F00D, 1, 0, 32'h0,        0, "sh_22"));
    tbl.push_back(mk(0, 32'h21,  32'h0,        0, 0, 32'hFFFFFF80, 0, "lb_21"));
    tbl.push_back(mk(0, 32'h21,  32'h0,        0, 1, 32'h00000080, 0, "lbu_21"));
    tbl.push_back(mk(0, 32'h22,  32'h0,        1, 1, 32'h0000F00D, 0, "lhu_22"));
    tbl.push_back(mk(0, 32'h22,  32'h0,        1, 0, 32'hFFFFF00D, 0, "lh_22"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        2, 0, 32'hF00D8044, 0, "lw_20"));
    tbl.push_back(mk(0, 32'h12,  32'h0,        2, 0, 32'h0,        1, "lw_12_misalign"));
    tbl.push_back(mk(1, 32'h23,  32'h00005555, 1, 0, 32'h0,        1, "sh_23_misalign"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        2, 0, 32'hF00D8044, 0, "lw_20_nochange"));
    tbl.push_back(mk(0, 32'h100, 32'h0,        2, 0, 32'h0,        1, "lw_oob"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        3, 0, 32'h0,        1, "ld_size11"));
    tbl.push_back(mk(1, 32'h20,  32'hFFFFFFFF, 3, 0, 32'h0,        1, "st_size11"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        2, 0, 32'hF00D8044, 0, "lw_20_after_ill"));
    tbl.push_back(mk(0, 32'hFFFFFFFC, 32'h0,   2, 0, 32'h0,        1, "lw_underflow"));
    tbl.push_back(mk(1, 32'h23,  32'h123456AB, 0, 0, 32'h0,        0, "sb_23"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        2, 0, 32'hAB0D8044, 0, "lw_20_b3"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        1, 0, 32'hFFFF8044, 0, "lh_20"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        0, 1, 32'h00000044, 0, "lbu_20"));
    tbl.push_back(mk(1, 32'h20,  32'h00007A7B, 1, 0, 32'h0,        0, "sh_20"));
    tbl.push_back(mk(0, 32'h20,  32'h0,        2, 0, 32'hAB0D7A7B, 0, "lw_20_h"));
    tbl.push_back(mk(1, 32'hFC,  32'h01020304, 2, 0, 32'h0,        0, "sw_last"));
    tbl.push_back(mk(0, 32'hFF,  32'h0,        0, 0, 32'h00000001, 0, "lb_last_byte"));

    foreach (tbl[i]) begin
      do_req(1, tbl[i].we, M_BASE + tbl[i].off, tbl[i].wd, tbl[i].sz, tbl[i].un, rd, er, lat);
      model_access(tbl[i].we, M_BASE + tbl[i].off, tbl[i].wd, tbl[i].sz, tbl[i].un, mrd, mer);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
      check({tbl[i].name, "_err"}, {31'd0, er}, {31'd0, tbl[i].exp_err});
      check({tbl[i].name, "_lat"}, 32'(lat), 32'd2);
    end

    // ---------------- reset during WAIT discards the store ----------------
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = M_BASE + 32'h30;
    req_wdata[1] = 32'h12345678; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    check("midrst_ready", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("midrst_wait_valid", {31'd0, rsp_valid[1]}, 32'd0);
    rstn[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst_valid", {31'd0, rsp_valid[1]}, 32'd0);
      check("midrst_ready_low", {31'd0, req_ready[1]}, 32'd0);
    end
    rstn[1] = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", {31'd0, req_ready[1]}, 32'd1);
    do_req(1, 1'b0, M_BASE + 32'h30, 32'h0, 2'd2, 1'b0, rd, er, lat);
    model_access(1'b0, M_BASE + 32'h30, 32'h0, 2'd2, 1'b0, mrd, mer);
    check("midrst_lw30", rd, mrd);
    check("midrst_lw30_err", {31'd0, er}, 32'd0);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      r  = int'($urandom_range(0, 19));
      if (r == 0)      off = 32'(4*M_DEPTH) + $urandom_range(0, 15);
      else if (r == 1) off = 32'd0 - $urandom_range(1, 8);
      else begin
        off = $urandom_range(0, 4*M_DEPTH - 1);
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) off = off & ~32'd1;
          if (sz == 2'd2) off = off & ~32'd3;
        end
      end
      v = $urandom();
      do_req(1, we, M_BASE + off, v, sz, un, rd, er, lat);
      model_access(we, M_BASE + off, v, sz, un, mrd, mer);
      check($sformatf("rand%0d_rdata", i), rd, mrd);
      check($sformatf("rand%0d_err", i), {31'd0, er}, {31'd0, mer});
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'd2);
    end

    // ---------------- WAIT_CYCLES=0: back-to-back accepts ----------------
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0;
    req_wdata[0] = 32'h5A5A5A5A; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_ready%0d", k), {31'd0, req_ready[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_valid%0d", k), {31'd0, rsp_valid[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    do_req(0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("w0_lw_rdata", rd, 32'h5A5A5A5A);
    check("w0_lw_lat", 32'(lat), 32'd1);

    // ---------------- WAIT_CYCLES=3: latency and ignored mid-WAIT inputs ----------------
    do_req(2, 1'b1, 32'h8, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("w3_sw8_lat", 32'(lat), 32'd4);
    check("w3_sw8_err", {31'd0, er}, 32'd0);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h4;
    req_wdata[2] = 32'hAAAA0001; req_size[2] = 2'd2; req_unsigned[2] = 1'b0;
    @(posedge clk);
    #1;
    req_addr[2] = 32'h8; req_wdata[2] = 32'hBBBBBBBB;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("w3_resp_valid", {31'd0, rsp_valid[2]}, 32'd1);
        check("w3_resp_err", {31'd0, rsp_err[2]}, 32'd0);
        req_valid[2] = 1'b0;
      end else begin
        check($sformatf("w3_novalid%0d", i), {31'd0, rsp_valid[2]}, 32'd0);
      end
    end
    do_req(2, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("w3_lw4", rd, 32'hAAAA0001);
    check("w3_lw4_lat", 32'(lat), 32'd4);
    do_req(2, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("w3_lw8_unchanged", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's fetch, load and store requests.
- It is the slave end of the core's memory request interface.
- Accepts one request at a time and inserts a configurable number of wait states.
- Performs byte, halfword or word access on an internal word array, and returns read data or an error response.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
WAIT_CYCLES, 1, wait states between accept and response; 0 to 15 allowed.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  reset, synchronous, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  responder can accept a request
req_we_i  input  1  1 = store, 0 = load or fetch
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned
req_size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned_i  input  1  load zero-extend (LBU/LHU)
rsp_valid_o  output  1  one-cycle response strobe
rsp_rdata_o  output  32  extended load data; 0 for stores and errors
rsp_err_o  output  1  access fault, valid with rsp_valid_o

Behaviour:
- Reset (rstn_i low at a rising edge):
  - State goes to IDLE, wait counter to 0.
  - req_ready_o=0 during reset; it is 1 in the first IDLE cycle after release.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Array contents are not cleared.
  - A store pending at reset is discarded; no write occurs.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o at a rising edge, latch we, addr, wdata, size and unsigned.
  - Next state is WAIT with counter=WAIT_CYCLES when WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready_o=0; the counter decrements each cycle.
  - When the counter equals 1, next state is RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, and rsp_rdata_o and rsp_err_o are valid in that cycle.
  - req_ready_o=0; next state is IDLE.
- Latency: rsp_valid_o asserts WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: a new request is accepted no sooner than the cycle after RESP. With WAIT_CYCLES=0, the accept-to-accept interval is 2 cycles.
- Request inputs are ignored outside IDLE. No response backpressure: the requester must sample in the RESP cycle.
- Address decode:
  - offset = req_addr_i - BASE_ADDR.
  - word index = offset[31:2].
  - lane = offset[1:0].
- Error conditions:
  - req_size_i = 11.
  - Half access with lane[0] = 1.
  - Word access with lane != 0.
  - Word index >= DEPTH_WORDS, including offset underflow when req_addr_i < BASE_ADDR.
  - On error: rsp_err_o=1, rsp_rdata_o=0, and no array write.
- Loads:
  - Read the word, shift right by lane*8, and take 8 or 16 or 32 bits.
  - Sign-extend unless req_unsigned_i=1.
  - req_unsigned_i is ignored for word accesses.
- Stores:
  - Byte-enable merge: a byte store writes lane only; a half store writes lanes lane and lane+1; a word store writes all lanes.
  - Data comes from req_wdata_i[7:0] or [15:0] or [31:0], replicated or shifted to the lane position.
  - The write commits at the rising edge ending the RESP cycle, and only when there is no error.
  - For stores, rsp_rdata_o=0.
- Read-after-write: a load accepted after a store's RESP returns the new data.
- Errors are reported once per request; the FSM always returns to IDLE, with no sticky error state.

Test Plan:
- Reset, then check idle: hold rstn_i low 2 cycles -> rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; req_ready_o=1 in the first cycle after release.
- Word store then word load:
  - WAIT_CYCLES=1: SW 32'hDEADBEEF @0x10 -> rsp_valid_o exactly 2 cycles after accept, err=0.
  - LW @0x10 -> rsp_rdata_o=32'hDEADBEEF.
- Byte and half lanes:
  - Stores: SB 8'h80 @0x21, then SH 16'hF00D @0x22.
  - LB @0x21 -> 32'hFFFFFF80; LBU @0x21 -> 32'h00000080.
  - LHU @0x22 -> 32'h0000F00D; LW @0x20 -> 32'hF00D80xx, with byte 0 unchanged.
- Misaligned and out-of-range:
  - LW @0x12 -> err=1, rdata=0.
  - SH @0x23 -> err=1, and a following LW @0x20 shows no change.
  - LW @(BASE_ADDR + 4*DEPTH_WORDS) -> err=1.
  - req_size_i=11 -> err=1.
- Handshake timing:
  - WAIT_CYCLES=0: back-to-back requests held valid -> accepts on alternating cycles; req_ready_o=0 in RESP.
  - WAIT_CYCLES=3: latency is 4 cycles, and a request changed mid-WAIT is ignored.
- Reset mid-operation: SW 32'h12345678 @0x30 accepted, rstn_i low during WAIT -> no rsp_valid_o; LW @0x30 returns the prior contents.
